// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state encoding and default timing constants
// for the stepper step/direction generator.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN_AUTO,
    RUN_MOVE,
    RUN_N
  } state_t;

  localparam int DEF_MANUAL_PERIOD = 2000;
  localparam int DEF_DIR_SETUP     = 8;
  localparam int DEF_MIN_PERIOD    = 4;

endpackage

// File: rtl/stepper_step_gen_if.sv
// stepper_step_gen_if: control inputs (master drives) and pin/status
// outputs (slave drives) of the stepper step generator.
interface stepper_step_gen_if #(
  parameter int CNT_W  = 16,
  parameter int STEP_W = 16
);
  logic              drv_en;
  logic              auto;
  logic              start;
  logic              start_n;
  logic              stop;
  logic              dir_in;
  logic [CNT_W-1:0]  period_auto;
  logic [STEP_W-1:0] n_steps;
  logic [CNT_W-1:0]  ramp_start;
  logic [CNT_W-1:0]  ramp_dec;
  logic              step;
  logic              dir;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_cnt;

  modport master (
    output drv_en, auto, start, start_n, stop, dir_in,
    output period_auto, n_steps, ramp_start, ramp_dec,
    input  step, dir, busy, done, step_cnt
  );

  modport slave (
    input  drv_en, auto, start, start_n, stop, dir_in,
    input  period_auto, n_steps, ramp_start, ramp_dec,
    output step, dir, busy, done, step_cnt
  );
endinterface

// File: rtl/step_period_engine.sv
// step_period_engine: period counter, clamped period reload with linear
// ramp, step shaping; emits wrap (last cycle) and rise (first cycle).
module step_period_engine
  import stepper_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MANUAL_PERIOD = DEF_MANUAL_PERIOD,
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             auto_mode,
  input  logic             first_auto,
  input  logic             drv_en,
  input  logic [CNT_W-1:0] period_auto,
  input  logic [CNT_W-1:0] ramp_start,
  input  logic [CNT_W-1:0] ramp_dec,
  output logic             step,
  output logic             wrap,
  output logic             rise
);

  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MANP = CNT_W'(MANUAL_PERIOD);
  localparam logic [CNT_W-1:0] FLOOR = (MANP < MINP) ? MINP : MANP;

  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] first_p;
  logic [CNT_W-1:0] next_p;
  logic [CNT_W-1:0] ramp_p;
  logic             hold;

  function automatic logic [CNT_W-1:0] clamp(
    input logic [CNT_W-1:0] v
  );
    return (v < MINP) ? MINP : v;
  endfunction

  always_comb begin
    hold = auto_mode && !drv_en;
    hi = p >> 2;
    if (hi == '0) hi = CNT_W'(1);
    ramp_p = (ramp_start > FLOOR) ? ramp_start : FLOOR;
    first_p = first_auto ? clamp(period_auto) : ramp_p;
    // p never drops below FLOOR in MOVE modes, so p - FLOOR is safe
    if (auto_mode)
      next_p = clamp(period_auto);
    else if ((p - FLOOR) > ramp_dec)
      next_p = p - ramp_dec;
    else
      next_p = FLOOR;
    step = run && !hold && (pc < hi);
    wrap = run && !hold && (pc == p - CNT_W'(1));
    rise = step && (pc == '0);
  end

  // While idle/setup, p tracks the first period so RUN starts with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      p  <= FLOOR;
    end else if (!run) begin
      pc <= '0;
      p  <= first_p;
    end else if (hold) begin
      pc <= '0;
    end else if (wrap) begin
      pc <= '0;
      p  <= next_p;
    end else begin
      pc <= pc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_step_gen.sv
// stepper_step_gen: step/dir generator FSM (AUTO, MOVE, MOVE_N) with
// dir setup, ramp, graceful stop and busy/done; ports via bus.slave.
module stepper_step_gen
  import stepper_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int STEP_W        = 16,
  parameter int MANUAL_PERIOD = DEF_MANUAL_PERIOD,
  parameter int DIR_SETUP     = DEF_DIR_SETUP,
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD
) (
  input logic               clk,
  input logic               rst,
  stepper_step_gen_if.slave bus
);

  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam logic [SW-1:0] S_LAST = SW'(DIR_SETUP - 1);

  state_t            state;
  state_t            tgt;
  logic              dir_q;
  logic              busy_q;
  logic              done_q;
  logic              stop_req;
  logic [STEP_W-1:0] cnt_q;
  logic [STEP_W-1:0] n_lat;
  logic [CNT_W-1:0]  rs_lat;
  logic [CNT_W-1:0]  rd_lat;
  logic [SW-1:0]     scnt;
  logic              run;
  logic              step_w;
  logic              wrap;
  logic              rise;
  logic              go;

  assign run = (state == RUN_AUTO) || (state == RUN_MOVE) ||
               (state == RUN_N);
  assign go = !bus.stop && (bus.auto || bus.start ||
              (bus.start_n && (bus.n_steps != '0)));

  step_period_engine #(
    .CNT_W         (CNT_W),
    .MANUAL_PERIOD (MANUAL_PERIOD),
    .MIN_PERIOD    (MIN_PERIOD)
  ) u_eng (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .auto_mode   (state == RUN_AUTO),
    .first_auto  (tgt == RUN_AUTO),
    .drv_en      (bus.drv_en),
    .period_auto (bus.period_auto),
    .ramp_start  (rs_lat),
    .ramp_dec    (rd_lat),
    .step        (step_w),
    .wrap        (wrap),
    .rise        (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= IDLE;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_req <= 1'b0;
      cnt_q    <= '0;
      n_lat    <= '0;
      rs_lat   <= '0;
      rd_lat   <= '0;
      scnt     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          stop_req <= 1'b0;
          scnt     <= '0;
          if (go) begin
            state  <= SETUP;
            busy_q <= 1'b1;
            dir_q  <= bus.dir_in;
            n_lat  <= bus.n_steps;
            rs_lat <= bus.ramp_start;
            rd_lat <= bus.ramp_dec;
            cnt_q  <= '0;
            tgt    <= bus.auto  ? RUN_AUTO :
                      bus.start ? RUN_MOVE : RUN_N;
          end else if (!bus.stop && bus.start_n) begin
            done_q <= 1'b1;
          end
        end
        SETUP: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (scnt == S_LAST) begin
            state <= tgt;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        RUN_AUTO: begin
          // a gated driver has no pulse in flight, so exit at once
          if ((!bus.auto || bus.stop || stop_req) &&
              (wrap || !bus.drv_en)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.stop) begin
            stop_req <= 1'b1;
          end
        end
        RUN_MOVE: begin
          if (wrap && (bus.stop || stop_req)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.stop) begin
            stop_req <= 1'b1;
          end
        end
        RUN_N: begin
          if (rise) cnt_q <= cnt_q + STEP_W'(1);
          if (wrap && (bus.stop || stop_req)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (wrap && (cnt_q == n_lat)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (bus.stop) begin
            stop_req <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step     = step_w;
  assign bus.dir      = dir_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: directed self-checking bench for stepper_step_gen
// with default parameters (MANUAL_PERIOD 2000, DIR_SETUP 8, MIN_PERIOD 4).
module tb_stepper_step_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stepper_step_gen_if bus ();

  stepper_step_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    while (!bus.step && k < 100) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic high_len(output int h);
    h = 0;
    while (bus.step && h < 5000) begin
      cyc(1);
      h++;
    end
  endtask

  task automatic low_len(output int l);
    l = 0;
    while (!bus.step && bus.busy && l < 5000) begin
      cyc(1);
      l++;
    end
  endtask

  task automatic busy_len(output int m);
    m = 0;
    while (bus.busy && m < 5000) begin
      cyc(1);
      m++;
    end
  endtask

  initial begin
    int k, h, l, m;
    int ep[4];
    logic seen;
    ep = '{2600, 2400, 2200, 2000};
    bus.drv_en = 0;
    bus.auto = 0;
    bus.start = 0;
    bus.start_n = 0;
    bus.stop = 0;
    bus.dir_in = 0;
    bus.period_auto = '0;
    bus.n_steps = '0;
    bus.ramp_start = '0;
    bus.ramp_dec = '0;
    cyc(2);
    chk("rst_step", bus.step, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.step_cnt, 0);
    rst = 0;
    cyc(1);
    chk("idle_busy", bus.busy, 0);

    // MOVE_N, 5 steps, no ramp
    bus.dir_in = 1;
    bus.n_steps = 5;
    bus.start_n = 1;
    cyc(1);
    bus.start_n = 0;
    chk("n_busy", bus.busy, 1);
    chk("n_dir", bus.dir, 1);
    wait_rise(k);
    chk("n_setup", k, 8);
    bus.dir_in = 0;
    for (int i = 0; i < 5; i++) begin
      high_len(h);
      low_len(l);
      chk($sformatf("n_high%0d", i), h, 500);
      chk($sformatf("n_per%0d", i), h + l, 2000);
    end
    chk("n_dir_hold", bus.dir, 1);
    chk("n_done", bus.done, 1);
    chk("n_idle", bus.busy, 0);
    chk("n_cnt", bus.step_cnt, 5);
    cyc(1);
    chk("n_done_1cyc", bus.done, 0);
    chk("n_cnt_hold", bus.step_cnt, 5);

    // MOVE with ramp, stop mid-period
    bus.ramp_start = 2600;
    bus.ramp_dec = 200;
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    chk("m_dir", bus.dir, 0);
    chk("m_cnt_clr", bus.step_cnt, 0);
    wait_rise(k);
    chk("m_setup", k, 8);
    for (int i = 0; i < 4; i++) begin
      high_len(h);
      low_len(l);
      chk($sformatf("m_high%0d", i), h, ep[i] >> 2);
      chk($sformatf("m_per%0d", i), h + l, ep[i]);
    end
    cyc(100);
    bus.stop = 1;
    cyc(1);
    bus.stop = 0;
    busy_len(m);
    chk("m_stop_len", m, 1899);
    chk("m_no_done", bus.done, 0);
    chk("m_step_lo", bus.step, 0);
    chk("m_cnt", bus.step_cnt, 0);

    // AUTO, period 10 then 20, drv_en gating
    bus.period_auto = 10;
    bus.drv_en = 1;
    bus.auto = 1;
    cyc(1);
    wait_rise(k);
    chk("a_setup", k, 8);
    high_len(h);
    low_len(l);
    chk("a_high10", h, 2);
    chk("a_low10", l, 8);
    cyc(3);
    bus.period_auto = 20;
    low_len(l);
    chk("a_old_tail", l, 7);
    high_len(h);
    low_len(l);
    chk("a_high20", h, 5);
    chk("a_low20", l, 15);
    bus.drv_en = 0;
    #1;
    chk("a_gate_now", bus.step, 0);
    cyc(3);
    chk("a_gate_hold", bus.step, 0);
    chk("a_gate_busy", bus.busy, 1);
    bus.drv_en = 1;
    #1;
    chk("a_resume", bus.step, 1);
    high_len(h);
    low_len(l);
    chk("a_res_high", h, 5);
    chk("a_res_low", l, 15);
    bus.auto = 0;
    busy_len(m);
    chk("a_exit_wrap", m, 20);
    chk("a_no_done", bus.done, 0);

    // AUTO clamp: period 1 -> 4
    bus.period_auto = 1;
    bus.auto = 1;
    cyc(1);
    wait_rise(k);
    chk("c_setup", k, 8);
    high_len(h);
    low_len(l);
    chk("c_high", h, 1);
    chk("c_low", l, 3);
    bus.drv_en = 0;
    bus.auto = 0;
    cyc(1);
    chk("c_gated_exit", bus.busy, 0);
    bus.drv_en = 1;

    // start_n with zero steps
    bus.n_steps = 0;
    bus.start_n = 1;
    cyc(1);
    bus.start_n = 0;
    chk("z_done", bus.done, 1);
    chk("z_busy", bus.busy, 0);
    chk("z_step", bus.step, 0);
    cyc(1);
    chk("z_done_1cyc", bus.done, 0);

    // stop during SETUP
    bus.ramp_start = 0;
    bus.ramp_dec = 0;
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    chk("s_busy", bus.busy, 1);
    cyc(3);
    bus.stop = 1;
    cyc(1);
    bus.stop = 0;
    chk("s_idle", bus.busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | bus.step | bus.done;
      cyc(1);
    end
    chk("s_quiet", seen, 0);

    // start and start_n together -> MOVE
    bus.n_steps = 3;
    bus.start = 1;
    bus.start_n = 1;
    cyc(1);
    bus.start = 0;
    bus.start_n = 0;
    wait_rise(k);
    chk("g_setup", k, 8);
    cyc(6000);
    chk("g_still_busy", bus.busy, 1);
    chk("g_no_count", bus.step_cnt, 0);
    bus.stop = 1;
    cyc(1);
    bus.stop = 0;
    busy_len(m);
    chk("g_stop_len", m, 1999);

    // asynchronous reset mid RUN_N with step high
    bus.dir_in = 1;
    bus.n_steps = 5;
    bus.start_n = 1;
    cyc(1);
    bus.start_n = 0;
    wait_rise(k);
    cyc(1);
    chk("r_step_hi", bus.step, 1);
    chk("r_cnt1", bus.step_cnt, 1);
    rst = 1;
    #1;
    chk("r_step", bus.step, 0);
    chk("r_dir", bus.dir, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    chk("r_cnt", bus.step_cnt, 0);
    cyc(2);
    rst = 0;
    cyc(2);
    chk("r_idle_busy", bus.busy, 0);
    chk("r_idle_step", bus.step, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
